// File: rtl/otter_fetch_queue.sv
// Instruction fetch with a DEPTH-entry {pc, ir} prefetch queue; issue at t gives DEC_VALID at t+2.
// Stalls when queue + in-flight word would overflow; redirect flushes queue and the in-flight word.
module otter_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                         CLK,
    input  logic                         RST,
    output logic [31:0]                  IMEM_ADDR,
    output logic                         IMEM_RD,
    input  logic [31:0]                  IMEM_DOUT,
    input  logic                         REDIRECT,
    input  logic [31:0]                  REDIRECT_PC,
    input  logic                         DEC_READY,
    output logic                         DEC_VALID,
    output logic [31:0]                  DEC_IR,
    output logic [31:0]                  DEC_PC,
    output logic [$clog2(DEPTH+1)-1:0]   COUNT
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   inflight_pc_q, inflight_pc_d;
    logic          inflight_q, inflight_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   pc_mem [DEPTH];
    logic [31:0]   ir_mem [DEPTH];
    logic          pop, push, issue;
    logic [CW:0]   occupancy;

    always_comb begin
        DEC_VALID = !RST && !REDIRECT && (count_q != '0);
        pop       = DEC_VALID && DEC_READY;
        // Slots committed after this cycle's pop; the in-flight word needs a free slot.
        occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
        issue     = !RST && !REDIRECT && (occupancy < (CW+1)'(DEPTH));
        push      = inflight_q && !REDIRECT;
        IMEM_RD   = issue;
        IMEM_ADDR = fetch_pc_q;
        DEC_PC    = DEC_VALID ? pc_mem[rd_ptr_q] : 32'h0;
        DEC_IR    = DEC_VALID ? ir_mem[rd_ptr_q] : 32'h0;
        COUNT     = RST ? '0 : count_q;
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = inflight_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        if (REDIRECT) begin
            fetch_pc_d = {REDIRECT_PC[31:2], 2'b00};
            inflight_d = 1'b0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            rd_ptr_d   = rd_ptr_q + PW'(pop);
            wr_ptr_d   = wr_ptr_q + PW'(push);
            count_d    = count_q + CW'(push) - CW'(pop);
            inflight_d = issue;
            if (issue) begin
                inflight_pc_d = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + 32'd4;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= 32'h0;
            inflight_q    <= 1'b0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST && push) begin
            pc_mem[wr_ptr_q] <= inflight_pc_q;
            ir_mem[wr_ptr_q] <= IMEM_DOUT;
        end
    end
endmodule

// File: tb/tb_otter_fetch_queue.sv
// Randomised bench for otter_fetch_queue: queue-level reference model feeds a scoreboard checked at negedge.
module tb_otter_fetch_queue;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h100;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_RD;
    logic [31:0] IMEM_DOUT = 32'h0;
    logic        REDIRECT = 1'b0;
    logic [31:0] REDIRECT_PC = 32'h0;
    logic        DEC_READY = 1'b0;
    logic        DEC_VALID;
    logic [31:0] DEC_IR;
    logic [31:0] DEC_PC;
    logic [2:0]  COUNT;

    always #5 CLK = ~CLK;

    otter_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .CLK(CLK), .RST(RST), .IMEM_ADDR(IMEM_ADDR), .IMEM_RD(IMEM_RD),
        .IMEM_DOUT(IMEM_DOUT), .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
        .DEC_READY(DEC_READY), .DEC_VALID(DEC_VALID), .DEC_IR(DEC_IR),
        .DEC_PC(DEC_PC), .COUNT(COUNT)
    );

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] key = 32'h0;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ key;
    endfunction

    // Synchronous instruction memory: data for an address strobed at an edge appears after it.
    always @(posedge CLK) IMEM_DOUT <= IMEM_RD ? word(IMEM_ADDR) : 32'hBAD0C0DE;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic        rd;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
        logic [31:0] ir;
        logic [2:0]  cnt;
    } exp_t;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } ent_t;

    exp_t        exp_q[$];
    ent_t        m_fifo[$];
    logic        m_infl = 1'b0;
    logic [31:0] m_infl_pc = 32'h0;
    logic [31:0] m_pc = 32'h0;
    logic        m_known = 1'b0;

    // One clock of stimulus: predict outputs, queue them, then advance the model past the edge.
    task automatic step(input logic rst, input logic redir, input logic [31:0] rpc, input logic rdy);
        exp_t e;
        ent_t n;
        logic pop;
        RST = rst; REDIRECT = redir; REDIRECT_PC = rpc; DEC_READY = rdy;
        e.vld  = !rst && !redir && (m_fifo.size() > 0);
        pop    = e.vld && rdy;
        e.rd   = !rst && !redir && (m_fifo.size() + int'(m_infl) - int'(pop) < DEPTH);
        e.addr = m_pc;
        e.pc   = e.vld ? m_fifo[0].pc : 32'h0;
        e.ir   = e.vld ? m_fifo[0].ir : 32'h0;
        e.cnt  = rst ? 3'd0 : 3'(m_fifo.size());
        if (m_known) exp_q.push_back(e);
        @(posedge CLK); #1;
        if (rst) begin
            m_fifo.delete(); m_infl = 1'b0; m_pc = RPC; m_known = 1'b1;
        end else if (redir) begin
            m_fifo.delete(); m_infl = 1'b0; m_pc = {rpc[31:2], 2'b00};
        end else begin
            if (pop) void'(m_fifo.pop_front());
            if (m_infl) begin
                n.pc = m_infl_pc; n.ir = word(m_infl_pc);
                m_fifo.push_back(n);
            end
            if (e.rd) begin
                m_infl_pc = m_pc; m_pc = m_pc + 32'd4; m_infl = 1'b1;
            end else m_infl = 1'b0;
        end
    endtask

    exp_t mon_e;
    logic prev_rd = 1'b0;
    initial begin
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("imem_rd",   32'(IMEM_RD),   32'(mon_e.rd));
                chk("imem_addr", IMEM_ADDR,      mon_e.addr);
                chk("dec_valid", 32'(DEC_VALID), 32'(mon_e.vld));
                chk("dec_pc",    DEC_PC,         mon_e.pc);
                chk("dec_ir",    DEC_IR,         mon_e.ir);
                chk("count",     32'(COUNT),     32'(mon_e.cnt));
            end
            if (prev_rd && !RST && !REDIRECT)
                chk("push_into_full", 32'(COUNT == 3'(DEPTH) && !(DEC_VALID && DEC_READY)), 32'h0);
            prev_rd = IMEM_RD;
        end
    end

    initial begin
        // Reset, then stream with decode always ready.
        repeat (3) step(1, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        #1;
        chk("t1_first_valid", 32'(DEC_VALID), 32'h1);
        chk("t1_first_pc",    DEC_PC,         32'h100);
        repeat (12) step(0, 0, 0, 1);

        // Back-pressure fill, then drain.
        step(1, 0, 0, 0);
        repeat (8) step(0, 0, 0, 0);
        #1;
        chk("t2_count_full", 32'(COUNT),   32'd4);
        chk("t2_rd_low",     32'(IMEM_RD), 32'h0);
        chk("t2_addr_hold",  IMEM_ADDR,    32'h110);
        repeat (8) step(0, 0, 0, 1);

        // Redirect mid-stream to an unaligned target.
        step(0, 1, 32'h2003, 1);
        repeat (8) step(0, 0, 0, 1);

        // Redirect while full with decode ready.
        repeat (8) step(0, 0, 0, 0);
        step(0, 1, 32'h3000, 1);
        repeat (6) step(0, 0, 0, 1);

        // Fetch address wraps past the top of memory.
        step(0, 1, 32'hFFFFFFF8, 1);
        repeat (8) step(0, 0, 0, 1);

        // Reset with three queued entries and a word in flight.
        step(0, 1, 32'h4000, 0);
        repeat (4) step(0, 0, 0, 0);
        step(1, 0, 0, 1);
        #1;
        chk("t6_valid", 32'(DEC_VALID), 32'h0);
        chk("t6_count", 32'(COUNT),     32'h0);
        chk("t6_rd",    32'(IMEM_RD),   32'h0);
        chk("t6_addr",  IMEM_ADDR,      RPC);
        repeat (8) step(0, 0, 0, 1);

        // Random traffic with a scrambled memory image.
        key = 32'h5A5A_C3C3;
        step(1, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 6, $urandom,
                 ($urandom % 3) != 0);
        end
        step(0, 0, 0, 1);
        @(negedge CLK); @(negedge CLK); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
